// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package control_pkg;

   localparam int ALU_CODE_W = 3;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_EXECUTEI = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_JAL      = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;

   typedef enum logic [3:0] {
      FETCH    = S_FETCH,
      DECODE   = S_DECODE,
      MEMADR   = S_MEMADR,
      MEMREAD  = S_MEMREAD,
      MEMWB    = S_MEMWB,
      MEMWRITE = S_MEMWRITE,
      EXECUTER = S_EXECUTER,
      EXECUTEI = S_EXECUTEI,
      ALUWB    = S_ALUWB,
      JAL      = S_JAL,
      BRANCH   = S_BRANCH
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b101;

   // Operation class handed from the FSM to the ALU decoder.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic       ADR_PC     = 1'b0;
   localparam logic       ADR_ALUOUT = 1'b1;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] IMM_I      = 2'b00;
   localparam logic [1:0] IMM_S      = 2'b01;
   localparam logic [1:0] IMM_B      = 2'b10;
   localparam logic [1:0] IMM_J      = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields onto the 3-bit ALU code.
module alu_decoder
   import control_pkg::*;
(
   input  logic [1:0]            alu_op,
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   input  logic                  op5,
   output logic [ALU_CODE_W-1:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB:   alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // op5 distinguishes R-type from I-type, so addi never subtracts.
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default:     alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I datapath.
// Optional macro BRANCH_NE_EN adds bne resolution in the BRANCH state.
module multicycle_control
   import control_pkg::*;
#(
   parameter int ALU_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             zero,
   output logic             pc_write,
   output logic             adr_src,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       imm_src,
   output logic [ALU_W-1:0] alu_control
);

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] alu_op;
   logic       branch_taken;

`ifdef BRANCH_NE_EN
   assign branch_taken = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);
`else
   assign branch_taken = (funct3 == 3'b000) & zero;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_reg <= FETCH;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      pc_write   = 1'b0;
      adr_src    = ADR_PC;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      imm_src    = IMM_I;
      alu_op     = ALUOP_ADD;
      case (state_reg)
         FETCH: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            state_next = DECODE;
         end
         DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_B;
            case (opcode)
               OP_LOAD, OP_STORE: state_next = MEMADR;
               OP_RTYPE:          state_next = EXECUTER;
               OP_ITYPE:          state_next = EXECUTEI;
               OP_JAL:            state_next = JAL;
               OP_BRANCH:         state_next = BRANCH;
               default:           state_next = FETCH;
            endcase
         end
         MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
            state_next = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_src    = ADR_ALUOUT;
            state_next = MEMWB;
         end
         MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         MEMWRITE: begin
            adr_src   = ADR_ALUOUT;
            mem_write = 1'b1;
         end
         EXECUTER: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         EXECUTEI: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         ALUWB: reg_write = 1'b1;
         JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_write   = 1'b1;
            state_next = ALUWB;
         end
         BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            pc_write  = branch_taken;
         end
         default: state_next = FETCH;
      endcase
      // Outputs are held quiet for the whole reset window, whatever state is held.
      if (reset) begin
         pc_write   = 1'b0;
         adr_src    = ADR_PC;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         result_src = RES_ALUOUT;
         alu_src_a  = SRCA_PC;
         alu_src_b  = SRCB_RS2;
         imm_src    = IMM_I;
         alu_op     = ALUOP_ADD;
      end
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (opcode[5]),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand-written
// sequences for store strobe timing and reset in the middle of a load.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic [17:0] act;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multicycle_control #(.ALU_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .zero        (zero),
      .pc_write    (pc_write),
      .adr_src     (adr_src),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_write   (reg_write),
      .result_src  (result_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .imm_src     (imm_src),
      .alu_control (alu_control)
   );

   // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, src_a, src_b, imm_src, alu}
   assign act = {pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, imm_src, alu_control};

   localparam logic [17:0] E_RST     = 18'd0;
   localparam logic [17:0] E_FETCH   = {5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};
   localparam logic [17:0] E_DEC     = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000};
   localparam logic [17:0] E_MA_L    = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000};
   localparam logic [17:0] E_MA_S    = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000};
   localparam logic [17:0] E_MR      = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [17:0] E_MWB     = {5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [17:0] E_MW      = {5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [17:0] E_ALUWB   = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [17:0] E_JAL     = {5'b10000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000};
   localparam logic [17:0] E_BR_T    = {5'b10000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001};
   localparam logic [17:0] E_BR_N    = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001};
   localparam logic [17:0] E_EXR_SUB = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001};
   localparam logic [17:0] E_EXR_SLT = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101};
   localparam logic [17:0] E_EXR_ADD = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000};
   localparam logic [17:0] E_EXR_OR  = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b011};
   localparam logic [17:0] E_EXI_ADD = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000};
   localparam logic [17:0] E_EXI_AND = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010};
`ifdef BRANCH_NE_EN
   localparam logic [17:0] E_BNE_Z0  = E_BR_T;
`else
   localparam logic [17:0] E_BNE_Z0  = E_BR_N;
`endif

   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        z;
      logic [17:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic z, input logic [17:0] exp);
      vec_t v;
      v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic z);
      reset = rst; opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   int mw_cnt, mw_cyc, rw_cnt, adr_at_mw, waited;

   initial begin
      add(1, 7'b0000011, 3'b010, 0, 0, E_RST);
      // lw: 5 cycles
      add(0, 7'b0000011, 3'b010, 0, 0, E_FETCH);
      add(0, 7'b0000011, 3'b010, 0, 0, E_DEC);
      add(0, 7'b0000011, 3'b010, 0, 0, E_MA_L);
      add(0, 7'b0000011, 3'b010, 0, 0, E_MR);
      add(0, 7'b0000011, 3'b010, 0, 0, E_MWB);
      // sw
      add(0, 7'b0100011, 3'b010, 0, 0, E_FETCH);
      add(0, 7'b0100011, 3'b010, 0, 0, E_DEC);
      add(0, 7'b0100011, 3'b010, 0, 0, E_MA_S);
      add(0, 7'b0100011, 3'b010, 0, 0, E_MW);
      // R-type sub, slt, add, or
      add(0, 7'b0110011, 3'b000, 1, 1, E_FETCH);
      add(0, 7'b0110011, 3'b000, 1, 1, E_DEC);
      add(0, 7'b0110011, 3'b000, 1, 1, E_EXR_SUB);
      add(0, 7'b0110011, 3'b000, 1, 1, E_ALUWB);
      add(0, 7'b0110011, 3'b010, 0, 0, E_FETCH);
      add(0, 7'b0110011, 3'b010, 0, 0, E_DEC);
      add(0, 7'b0110011, 3'b010, 0, 0, E_EXR_SLT);
      add(0, 7'b0110011, 3'b010, 0, 0, E_ALUWB);
      add(0, 7'b0110011, 3'b000, 0, 0, E_FETCH);
      add(0, 7'b0110011, 3'b000, 0, 0, E_DEC);
      add(0, 7'b0110011, 3'b000, 0, 0, E_EXR_ADD);
      add(0, 7'b0110011, 3'b000, 0, 0, E_ALUWB);
      add(0, 7'b0110011, 3'b110, 0, 0, E_FETCH);
      add(0, 7'b0110011, 3'b110, 0, 0, E_DEC);
      add(0, 7'b0110011, 3'b110, 0, 0, E_EXR_OR);
      add(0, 7'b0110011, 3'b110, 0, 0, E_ALUWB);
      // addi with funct7b5=1 stays add; andi
      add(0, 7'b0010011, 3'b000, 1, 0, E_FETCH);
      add(0, 7'b0010011, 3'b000, 1, 0, E_DEC);
      add(0, 7'b0010011, 3'b000, 1, 0, E_EXI_ADD);
      add(0, 7'b0010011, 3'b000, 1, 0, E_ALUWB);
      add(0, 7'b0010011, 3'b111, 0, 0, E_FETCH);
      add(0, 7'b0010011, 3'b111, 0, 0, E_DEC);
      add(0, 7'b0010011, 3'b111, 0, 0, E_EXI_AND);
      add(0, 7'b0010011, 3'b111, 0, 0, E_ALUWB);
      // jal
      add(0, 7'b1101111, 3'b000, 0, 0, E_FETCH);
      add(0, 7'b1101111, 3'b000, 0, 0, E_DEC);
      add(0, 7'b1101111, 3'b000, 0, 0, E_JAL);
      add(0, 7'b1101111, 3'b000, 0, 0, E_ALUWB);
      // beq taken / not taken, bne with zero=0, blt-coded funct3 with zero=1
      add(0, 7'b1100011, 3'b000, 0, 1, E_FETCH);
      add(0, 7'b1100011, 3'b000, 0, 1, E_DEC);
      add(0, 7'b1100011, 3'b000, 0, 1, E_BR_T);
      add(0, 7'b1100011, 3'b000, 0, 0, E_FETCH);
      add(0, 7'b1100011, 3'b000, 0, 0, E_DEC);
      add(0, 7'b1100011, 3'b000, 0, 0, E_BR_N);
      add(0, 7'b1100011, 3'b001, 0, 0, E_FETCH);
      add(0, 7'b1100011, 3'b001, 0, 0, E_DEC);
      add(0, 7'b1100011, 3'b001, 0, 0, E_BNE_Z0);
      add(0, 7'b1100011, 3'b100, 0, 1, E_FETCH);
      add(0, 7'b1100011, 3'b100, 0, 1, E_DEC);
      add(0, 7'b1100011, 3'b100, 0, 1, E_BR_N);
      // unknown opcode: 2-cycle nop
      add(0, 7'b0000000, 3'b000, 0, 0, E_FETCH);
      add(0, 7'b0000000, 3'b000, 0, 0, E_DEC);

      drive(1, 7'b0, 3'b0, 0, 0);
      next_cycle();
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z);
         @(negedge clk);
         check($sformatf("vec%0d_outputs", i), {14'd0, act}, {14'd0, tbl[i].exp});
         check($sformatf("vec%0d_pcw_memw_excl", i), {31'd0, pc_write & mem_write}, 32'd0);
         $display("vec %0d op=%b f3=%b rst=%0d outputs=%h", i, tbl[i].op, tbl[i].f3,
                  tbl[i].rst, act);
         next_cycle();
      end

      // Store: one mem_write pulse in its 4th cycle, with adr_src=1, no reg_write.
      mw_cnt = 0; mw_cyc = -1; rw_cnt = 0; adr_at_mw = 0;
      drive(0, 7'b0100011, 3'b010, 0, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (mem_write) begin
            mw_cnt++;
            mw_cyc = c;
            adr_at_mw = int'(adr_src);
         end
         if (reg_write) rw_cnt++;
         next_cycle();
      end
      check("sw_memwrite_count", mw_cnt, 1);
      check("sw_memwrite_cycle", mw_cyc, 3);
      check("sw_adr_src", adr_at_mw, 1);
      check("sw_no_regwrite", rw_cnt, 0);
      $display("seq sw mem_write_pulses=%0d at_cycle=%0d reg_writes=%0d", mw_cnt, mw_cyc, rw_cnt);

      // Load aborted by reset while in MEMREAD.
      drive(0, 7'b0000011, 3'b010, 0, 0);
      for (int c = 0; c < 3; c++) next_cycle();
      @(negedge clk);
      check("abort_in_memread", {14'd0, act}, {14'd0, E_MR});
      next_cycle();
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("abort_reset_quiet%0d", c), {14'd0, act}, 32'd0);
         next_cycle();
      end
      reset = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!ir_write && waited < 4) begin
         next_cycle();
         @(negedge clk);
         waited++;
      end
      check("abort_fetch_first_cycle", waited, 0);
      check("abort_fetch_outputs", {14'd0, act}, {14'd0, E_FETCH});
      next_cycle();
      @(negedge clk);
      check("abort_then_decode", {14'd0, act}, {14'd0, E_DEC});
      $display("seq reset_in_memread fetch_after_release_wait=%0d", waited);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control FSM for the multicycle RV32I datapath; the producer side of the ALU's alu_control/zero interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, and encodes alu_control using the ALU's 3-bit code.
- Consumes the ALU zero flag for branch resolution.

Parameters:
- ALU_W, 3, width of alu_control (fixed ALU encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt).

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag, same cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address mux: 0 = PC, 1 = ALUOut
- mem_write  output  1  data memory write strobe
- ir_write  output  1  instruction/oldPC register enable
- reg_write  output  1  register file write enable
- result_src  output  2  00 = ALUOut, 01 = data reg, 10 = ALU result
- alu_src_a  output  2  00 = PC, 01 = oldPC, 10 = rs1 reg
- alu_src_b  output  2  00 = rs2 reg, 01 = imm, 10 = const 4
- imm_src  output  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  output  ALU_W  ALU operation code

Behaviour:
- Moore FSM; state register updates on clk. Outputs are combinational from state, plus opcode/funct fields for alu_control and imm_src.
- Reset: state = FETCH on the next edge, abandoning any in-flight instruction. While reset is asserted, all enables/strobes = 0, alu_control = 000, all selects = 0.
- States and outputs (outputs not listed = 0):
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, add, result_src=10, pc_write=1. Next: DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, add (branch target into ALUOut). Next by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - any other opcode -> FETCH (executes as a nop; no write, no pc_write beyond FETCH).
  - MEMADR: alu_src_a=10, alu_src_b=01, add; imm_src=00 for load, 01 for store. Next: MEMREAD (load) or MEMWRITE (store).
  - MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE: adr_src=1, mem_write=1, result_src=00. Next: FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_control per ALU decode. Next: ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, imm_src=00, alu_control per ALU decode. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next: FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Next: ALUWB (writes oldPC+4 to rd).
  - BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write = taken. Next: FETCH.
- Branch taken rule: taken = (funct3 == 000) & zero. Other funct3 values are never taken.
- ALU decode (R-type/I-type) by funct3:
  - 000: sub iff R-type and funct7b5 = 1; otherwise add. For I-type, funct7b5 is ignored.
  - 010: slt
  - 110: or
  - 111: and
  - others: add
- Latency: load 5 cycles; store, R-type, I-type and jal 4; branch 3; unknown opcode 2.
- Exactly one state is active per cycle. pc_write and mem_write are never asserted together.

Optional Feature:
- BRANCH_NE_EN defined: BRANCH also handles bne, with taken = (funct3 == 000 & zero) | (funct3 == 001 & ~zero).
- Undefined: funct3 = 001 branches are never taken.

Decomposition:
- Shared package (control_pkg): state encoding localparams (4-bit), opcode constants, ALU code constants (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101), and mux select constants. The ALU and this block both use the package.
- Sub-module alu_decoder: combinational (aluop class, funct3, funct7b5, opcode[5]) -> alu_control. Keeps the FSM free of funct decoding.

Test Plan:
- lw (opcode 0000011) from reset -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5; alu_control=000 in MEMADR.
- R-type sub (funct3=000, funct7b5=1) -> alu_control=001 in EXECUTER; R-type slt -> 101; addi with funct7b5=1 -> 000.
- beq with zero=1 in BRANCH -> pc_write=1, back in FETCH next cycle; zero=0 -> pc_write=0.
- sw -> mem_write=1 for exactly one cycle (cycle 4) with adr_src=1; reg_write stays 0 throughout.
- Opcode 0000000 -> DECODE then FETCH; no reg_write or mem_write.
- Assert reset during MEMREAD -> all outputs 0 while reset is high; FETCH on the first cycle after release. With BRANCH_NE_EN, bne with zero=0 -> pc_write=1.
